rv32m_div_sequencer: RTL and testbench

Multi-cycle divide sequencer for the execute stage. It accepts RV32M DIV/DIVU/REM/REMU operations presented alongside the ALU, runs a 32-iteration restoring division, and holds the ALU stage through its force-stall input until the result is ready. The result is then returned with a one-cycle done strobe so the ALU stage can write it back as a normal rd value.

---
 rtl/rv32m_div_sequencer.sv | 161 ++++++++++++++++
 tb/tb_rv32m_div_sequencer.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rv32m_div_sequencer.sv
// RV32M DIV/DIVU/REM/REMU sequencer: 32-step restoring division that stalls the
// ALU stage until the quotient or remainder is ready for writeback.
module rv32m_div_sequencer (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_ce,
    input  logic [1:0]  i_op,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [4:0]  i_rd_addr,
    input  logic        i_flush,
    output logic        o_force_stall,
    output logic        o_busy,
    output logic        o_done,
    output logic [31:0] o_result,
    output logic [4:0]  o_rd_addr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREP,
        S_ITER,
        S_FIX,
        S_DONE
    } state_t;

    state_t      state;
    state_t      state_next;

    logic [1:0]  op_q;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic [4:0]  rd_q;
    logic        neg_q;
    logic        neg_r;
    logic [31:0] rem;
    logic [31:0] quo;
    logic [4:0]  count;

    logic        accept;
    logic        div_zero;
    logic        overflow;
    logic        op_signed;
    logic [31:0] abs_dividend;
    logic [31:0] abs_divisor;
    logic [32:0] trial;
    logic [31:0] quotient_fix;
    logic [31:0] remainder_fix;

    assign accept    = (state == S_IDLE) && i_valid && i_ce && !i_flush;
    assign div_zero  = (i_rs2 == 32'd0);
    assign overflow  = !i_op[0] && (i_rs1 == 32'h8000_0000) && (i_rs2 == 32'hFFFF_FFFF);
    assign op_signed = !op_q[0];

    assign abs_dividend = (op_signed && dividend[31]) ? (32'd0 - dividend) : dividend;
    assign abs_divisor  = (op_signed && divisor[31])  ? (32'd0 - divisor)  : divisor;

    // R never reaches the divisor between steps, so its 33rd bit only exists in the shifted trial value.
    assign trial = {rem, quo[31]} - {1'b0, divisor};

    assign quotient_fix  = neg_q ? (32'd0 - quo) : quo;
    assign remainder_fix = neg_r ? (32'd0 - rem) : rem;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    state_next = (div_zero || overflow) ? S_DONE : S_PREP;
                end
            end
            S_PREP:  state_next = S_ITER;
            S_ITER:  state_next = (count == 5'd31) ? S_FIX : S_ITER;
            S_FIX:   state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        if (i_flush) begin
            state_next = S_IDLE;
        end
    end

    always_comb begin
        o_busy        = (state != S_IDLE);
        o_done        = (state == S_DONE) && !i_flush;
        o_force_stall = !i_flush &&
                        (((state == S_IDLE) && i_valid && i_ce) ||
                         (state == S_PREP) || (state == S_ITER) || (state == S_FIX));
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            op_q      <= 2'd0;
            dividend  <= 32'd0;
            divisor   <= 32'd0;
            rd_q      <= 5'd0;
            neg_q     <= 1'b0;
            neg_r     <= 1'b0;
            rem       <= 32'd0;
            quo       <= 32'd0;
            count     <= 5'd0;
            o_result  <= 32'd0;
            o_rd_addr <= 5'd0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_q     <= i_op;
                        dividend <= i_rs1;
                        divisor  <= i_rs2;
                        rd_q     <= i_rd_addr;
                        // Special cases publish their result immediately and skip straight to DONE.
                        if (div_zero) begin
                            o_result  <= i_op[1] ? i_rs1 : 32'hFFFF_FFFF;
                            o_rd_addr <= i_rd_addr;
                        end else if (overflow) begin
                            o_result  <= i_op[1] ? 32'd0 : 32'h8000_0000;
                            o_rd_addr <= i_rd_addr;
                        end
                    end
                end
                S_PREP: begin
                    neg_q   <= op_signed && (dividend[31] ^ divisor[31]);
                    neg_r   <= op_signed && dividend[31];
                    quo     <= abs_dividend;
                    divisor <= abs_divisor;
                    rem     <= 32'd0;
                    count   <= 5'd0;
                end
                S_ITER: begin
                    if (!trial[32]) begin
                        rem <= trial[31:0];
                        quo <= {quo[30:0], 1'b1};
                    end else begin
                        rem <= {rem[30:0], quo[31]};
                        quo <= {quo[30:0], 1'b0};
                    end
                    count <= count + 5'd1;
                end
                S_FIX: begin
                    if (!i_flush) begin
                        o_result  <= op_q[1] ? remainder_fix : quotient_fix;
                        o_rd_addr <= rd_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32m_div_sequencer.sv
// Self-checking bench for rv32m_div_sequencer: directed corner cases plus random
// operations compared against a plain-arithmetic RV32M reference.
module tb_rv32m_div_sequencer;

    logic        clk;
    logic        rst;
    logic        valid;
    logic        ce;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [4:0]  rdAddr;
    logic        flush;
    logic        forceStall;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic [4:0]  resultRd;

    int checks = 0;
    int errors = 0;

    rv32m_div_sequencer dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_valid       (valid),
        .i_ce          (ce),
        .i_op          (op),
        .i_rs1         (rs1),
        .i_rs2         (rs2),
        .i_rd_addr     (rdAddr),
        .i_flush       (flush),
        .o_force_stall (forceStall),
        .o_busy        (busy),
        .o_done        (done),
        .o_result      (result),
        .o_rd_addr     (resultRd)
    );

    // Free-running 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for every check in the bench.
    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s got %h expected %h", tag, got, exp);
        end
    endtask

    // Inputs change mid-cycle on the falling edge, well away from the sampling edge.
    task automatic applyStimulus(input logic v, input logic [1:0] o, input logic [31:0] a,
                                 input logic [31:0] b, input logic [4:0] rd);
        @(negedge clk);
        valid  = v;
        op     = o;
        rs1    = a;
        rs2    = b;
        rdAddr = rd;
    endtask

    function automatic bit isSpecial(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        return (b == 32'd0) || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    endfunction

    // RISC-V M-extension semantics straight from the ISA rules.
    function automatic logic [31:0] refResult(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int sa;
        int sb;
        sa = a;
        sb = b;
        if (b == 32'd0) return o[1] ? a : 32'hFFFF_FFFF;
        if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return o[1] ? 32'd0 : 32'h8000_0000;
        case (o)
            2'b00:   return sa / sb;
            2'b01:   return a / b;
            2'b10:   return sa % sb;
            default: return a % b;
        endcase
    endfunction

    // Presents one op at cycle 0 and follows it to its done strobe.
    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] expResult, input bit holdValid);
        int expCycle;
        int doneCycle;
        bit stallOk;
        bit busyOk;
        expCycle  = isSpecial(o, a, b) ? 1 : 35;
        doneCycle = -1;
        stallOk   = 1'b1;
        busyOk    = 1'b1;
        applyStimulus(1'b1, o, a, b, rd);
        #1;
        if (!forceStall) stallOk = 1'b0;
        if (busy) busyOk = 1'b0;
        for (int c = 1; c <= 40 && doneCycle < 0; c++) begin
            @(negedge clk);
            if (!holdValid) valid = 1'b0;
            #1;
            if (done) begin
                doneCycle = c;
                checkOutput("stallInDone", {31'd0, forceStall}, 32'd0);
                checkOutput("busyInDone", {31'd0, busy}, 32'd1);
            end else begin
                if (!forceStall) stallOk = 1'b0;
                if (!busy) busyOk = 1'b0;
            end
        end
        checkOutput("doneCycle", doneCycle, expCycle);
        checkOutput("result", result, expResult);
        checkOutput("rdAddr", {27'd0, resultRd}, {27'd0, rd});
        checkOutput("stallWindow", {31'd0, stallOk}, 32'd1);
        checkOutput("busyWindow", {31'd0, busyOk}, 32'd1);
    endtask

    task automatic expectNoDone(input string tag, input int cycles);
        bit sawDone;
        sawDone = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            @(negedge clk);
            #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput(tag, {31'd0, sawDone}, 32'd0);
    endtask

    initial begin
        logic [1:0]  rOp;
        logic [31:0] rA;
        logic [31:0] rB;
        logic [4:0]  rRd;

        rst = 1'b1; valid = 1'b0; ce = 1'b1; op = 2'b00;
        rs1 = 32'd0; rs2 = 32'd0; rdAddr = 5'd0; flush = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("rstDone", {31'd0, done}, 32'd0);
        checkOutput("rstBusy", {31'd0, busy}, 32'd0);
        checkOutput("rstStall", {31'd0, forceStall}, 32'd0);
        checkOutput("rstResult", result, 32'd0);
        checkOutput("rstRd", {27'd0, resultRd}, 32'd0);

        // Directed signed/unsigned vectors.
        runOp(2'b00, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 1'b0);
        runOp(2'b10, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 1'b0);
        runOp(2'b11, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h0000_0001, 1'b0);
        runOp(2'b01, 32'hFFFF_FFFF, 32'd1, 5'd8, 32'hFFFF_FFFF, 1'b0);

        // Divide by zero and signed overflow shortcuts.
        runOp(2'b01, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1'b0);
        runOp(2'b10, 32'd5, 32'd0, 5'd10, 32'd5, 1'b0);
        runOp(2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1'b0);
        runOp(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0, 1'b0);

        // Result and rd must hold once the strobe has passed.
        @(negedge clk);
        #1;
        checkOutput("holdDone", {31'd0, done}, 32'd0);
        checkOutput("holdResult", result, 32'd0);
        checkOutput("holdRd", {27'd0, resultRd}, 32'd12);

        // Flush at ITER count 10 (cycle 12).
        applyStimulus(1'b1, 2'b01, 32'd100, 32'd7, 5'd13);
        for (int c = 1; c < 12; c++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        @(negedge clk);
        flush = 1'b1;
        #1;
        checkOutput("flushStall", {31'd0, forceStall}, 32'd0);
        checkOutput("flushNoDone", {31'd0, done}, 32'd0);
        @(negedge clk);
        flush = 1'b0;
        #1;
        checkOutput("flushIdle", {31'd0, busy}, 32'd0);
        expectNoDone("flushNeverDone", 40);
        runOp(2'b01, 32'd100, 32'd7, 5'd14, 32'd14, 1'b0);
        runOp(2'b11, 32'd100, 32'd7, 5'd15, 32'd2, 1'b0);

        // Flush beats acceptance; i_ce low blocks acceptance.
        applyStimulus(1'b1, 2'b01, 32'd50, 32'd3, 5'd16);
        flush = 1'b1;
        #1;
        checkOutput("flushAcceptStall", {31'd0, forceStall}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        flush = 1'b0;
        #1;
        checkOutput("flushAcceptBusy", {31'd0, busy}, 32'd0);
        applyStimulus(1'b1, 2'b01, 32'd50, 32'd3, 5'd16);
        ce = 1'b0;
        #1;
        checkOutput("ceLowStall", {31'd0, forceStall}, 32'd0);
        @(negedge clk);
        valid = 1'b0;
        ce = 1'b1;
        #1;
        checkOutput("ceLowBusy", {31'd0, busy}, 32'd0);

        // Reset at cycle 20 of an op.
        applyStimulus(1'b1, 2'b00, 32'd1000, 32'd3, 5'd17);
        for (int c = 1; c < 20; c++) begin
            @(negedge clk);
            valid = 1'b0;
        end
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("midRstDone", {31'd0, done}, 32'd0);
        checkOutput("midRstBusy", {31'd0, busy}, 32'd0);
        checkOutput("midRstStall", {31'd0, forceStall}, 32'd0);
        checkOutput("midRstResult", result, 32'd0);
        checkOutput("midRstRd", {27'd0, resultRd}, 32'd0);
        expectNoDone("midRstNeverDone", 40);

        // Back-to-back with i_valid held through DONE.
        runOp(2'b00, 32'hFFFF_FF9C, 32'd7, 5'd18, refResult(2'b00, 32'hFFFF_FF9C, 32'd7), 1'b1);
        runOp(2'b11, 32'd12345, 32'd100, 5'd19, refResult(2'b11, 32'd12345, 32'd100), 1'b1);
        runOp(2'b01, 32'd9, 32'd0, 5'd20, refResult(2'b01, 32'd9, 32'd0), 1'b1);
        runOp(2'b10, 32'h8000_0001, 32'hFFFF_FFFD, 5'd21, refResult(2'b10, 32'h8000_0001, 32'hFFFF_FFFD), 1'b0);

        // Random ops against the reference.
        for (int n = 0; n < 40; n++) begin
            rOp = 2'($urandom_range(0, 3));
            rA  = $urandom;
            rRd = 5'($urandom_range(0, 31));
            case ($urandom_range(0, 5))
                0:       rB = 32'd0;
                1:       begin rA = 32'h8000_0000; rB = 32'hFFFF_FFFF; end
                2:       rB = 32'($urandom_range(1, 15));
                3:       rB = 32'd0 - 32'($urandom_range(1, 15));
                default: rB = $urandom;
            endcase
            runOp(rOp, rA, rB, rRd, refResult(rOp, rA, rB), 1'b0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
